// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared types for the SPI master and its clock divider.
//   state_t    : transfer sequencer states
//   spi_mode_t : {cpol, cpha} pair latched with each command
//   MODE0..3   : the four standard SPI modes
// ----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_clk_gen.sv
// ----------------------------------------------------------------------------
// spi_clk_gen
// Half-period tick generator for SPI serial clocks.
// A tick is asserted for one clk cycle every div+1 cycles. Asserting restart
// makes the next cycle the first cycle of a fresh half-period.
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   restart : begin a new half-period on the next cycle
//   div     : half-period length minus one, in clk cycles
//   tick    : high in the last cycle of each half-period
// ----------------------------------------------------------------------------
module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = (cnt == div);

    // restart wins over tick so that a state change always begins a full
    // half-period, whatever the counter was doing before
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_multi.sv
// ----------------------------------------------------------------------------
// spi_master_multi
// Parametrised full-duplex SPI master, MSB first, one word per slave select.
// Mode (cpol/cpha), slave index and divider are latched with each command.
// A transfer keeps its slave select low for (2*WIDTH+2)*(clk_div+1) cycles:
// one setup half-period, 2*WIDTH clock half-periods, one hold half-period.
// Optional build macro: SPI_LOOPBACK_EN adds a 'loopback' input that feeds the
// registered mosi back as the sample source instead of miso.
// Ports:
//   clk, rst             : system clock, asynchronous active-low reset
//   tx_valid / tx_ready  : command handshake (accept when both high)
//   tx_data, tx_ss       : word to send and slave index
//   cpol, cpha, clk_div  : mode and half-period (clk_div+1 cycles)
//   rx_valid, rx_data    : one-cycle pulse with the received word
//   busy                 : transfer in progress
//   sclk, mosi, miso     : SPI serial lines
//   ss_n                 : active-low slave selects
//   loopback             : (SPI_LOOPBACK_EN only) internal mosi->miso path
// ----------------------------------------------------------------------------
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int  WIDTH  = 8,
    parameter int  NUM_SS = 4,
    parameter int  DIV_W  = 8,
    localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [WIDTH-1:0]  tx_data,
    input  logic [SS_W-1:0]   tx_ss,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
    output logic              rx_valid,
    output logic [WIDTH-1:0]  rx_data,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic [NUM_SS-1:0] ss_n
);

    localparam int EW = $clog2(2 * WIDTH + 1);

    state_t            state;
    state_t            next_state;
    spi_mode_t         mode_q;
    logic [DIV_W-1:0]  div_q;
    logic [SS_W-1:0]   ss_q;
    logic [WIDTH-1:0]  tx_shift;
    logic [WIDTH-1:0]  rx_shift;
    logic [EW-1:0]     edge_cnt;
    logic              tick;
    logic              accept;
    logic              state_change;
    logic              last_edge;
    logic              odd_edge;
    logic              sample_edge;
    logic              drive_edge;
    logic              miso_src;

    assign accept       = tx_valid && tx_ready;
    assign state_change = (next_state != state);
    assign last_edge    = (edge_cnt == EW'(2 * WIDTH - 1));
    // edge_cnt counts completed edges, so the edge about to happen is
    // edge_cnt+1; it is odd when edge_cnt is even
    assign odd_edge     = ~edge_cnt[0];
    assign sample_edge  = mode_q.cpha ? ~odd_edge : odd_edge;
    // in mode cpha=0 the MSB is already on mosi, and the final edge only
    // returns sclk to idle, so it must not shift a further bit out
    assign drive_edge   = mode_q.cpha ? odd_edge : (~odd_edge && !last_edge);

`ifdef SPI_LOOPBACK_EN
    assign miso_src = loopback ? mosi : miso;
`else
    assign miso_src = miso;
`endif

    spi_clk_gen #(
        .DIV_W(DIV_W)
    ) u_clk_gen (
        .clk    (clk),
        .rst    (rst),
        .restart(state_change),
        .div    (div_q),
        .tick   (tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; DONE can accept a new command directly
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SETUP;
            SETUP:   if (tick) next_state = XFER;
            XFER:    if (tick && last_edge) next_state = HOLD;
            HOLD:    if (tick) next_state = DONE;
            DONE:    next_state = accept ? SETUP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode; an out-of-range slave index matches no select line
    always_comb begin
        tx_ready = 1'b0;
        busy     = 1'b0;
        rx_valid = 1'b0;
        ss_n     = '1;
        case (state)
            IDLE: begin
                tx_ready = rst;
            end
            SETUP, XFER, HOLD: begin
                busy = 1'b1;
                for (int i = 0; i < NUM_SS; i++) begin
                    if (ss_q == SS_W'(i)) begin
                        ss_n[i] = 1'b0;
                    end
                end
            end
            DONE: begin
                tx_ready = 1'b1;
                rx_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Command latch, serial clock, shift registers and received word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= MODE0;
            div_q    <= '0;
            ss_q     <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            edge_cnt <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
        end else if (accept) begin
            mode_q   <= '{cpol: cpol, cpha: cpha};
            div_q    <= clk_div;
            ss_q     <= tx_ss;
            edge_cnt <= '0;
            sclk     <= cpol;
            if (!cpha) begin
                mosi     <= tx_data[WIDTH-1];
                tx_shift <= {tx_data[WIDTH-2:0], 1'b0};
            end else begin
                tx_shift <= tx_data;
            end
        end else if (state == XFER && tick) begin
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + EW'(1);
            if (sample_edge) begin
                rx_shift <= {rx_shift[WIDTH-2:0], miso_src};
            end
            if (drive_edge) begin
                mosi     <= tx_shift[WIDTH-1];
                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            end
        end else if (state == HOLD && tick) begin
            sclk    <= mode_q.cpol;
            rx_data <= rx_shift;
        end
    end

endmodule

// File: tb/tb_spi_master_multi.sv
// ----------------------------------------------------------------------------
// tb_spi_master_multi
// Self-checking bench for spi_master_multi (default parameters).
// A behavioural SPI slave watches sclk/ss_n, serves a response word on miso,
// collects mosi bits, and checks select timing and the received word against
// the command queue. Build with SPI_LOOPBACK_EN to also exercise loopback.
// ----------------------------------------------------------------------------
module tb_spi_master_multi;

    localparam int W        = 8;
    localparam int NSS      = 4;
    localparam int MAX_WAIT = 20000;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   ss;
        logic         cpol;
        logic         cpha;
        logic [7:0]   div;
        logic [W-1:0] resp;
        logic         lb;
    } txn_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           tx_valid = 1'b0;
    logic           tx_ready;
    logic [W-1:0]   tx_data = '0;
    logic [1:0]     tx_ss = '0;
    logic           cpol = 1'b0;
    logic           cpha = 1'b0;
    logic [7:0]     clk_div = '0;
    logic           rx_valid;
    logic [W-1:0]   rx_data;
    logic           busy;
    logic           sclk;
    logic           mosi;
    logic           miso = 1'b0;
    logic [NSS-1:0] ss_n;
`ifdef SPI_LOOPBACK_EN
    logic           loopback = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    txn_t exp_q[$];
    int   exp_pulses = 0;
    int   rx_pulses = 0;

    // slave / monitor state
    bit           mon_active = 1'b0;
    txn_t         cur;
    int           low_cycles;
    int           mon_edges = 0;
    int           drv_idx;
    logic [W-1:0] mosi_cap;
    logic         prev_sclk;
    logic [3:0]   prev_ss = 4'hF;

    spi_master_multi #(
        .WIDTH (W),
        .NUM_SS(NSS),
        .DIV_W (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data (tx_data),
        .tx_ss   (tx_ss),
        .cpol    (cpol),
        .cpha    (cpha),
        .clk_div (clk_div),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .busy    (busy),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
`ifdef SPI_LOOPBACK_EN
        .loopback(loopback),
`endif
        .ss_n    (ss_n)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural slave: acts on sclk changes seen at the falling clk edge,
    // so master outputs are settled and miso changes well before sampling.
    always @(negedge clk) begin
        logic       lead;
        logic [3:0] exp_ss;
        logic [W-1:0] exp_rx;
        if (!rst) begin
            mon_active = 1'b0;
            prev_ss    = 4'hF;
        end else begin
            if (rx_valid) rx_pulses++;
            if (ss_n !== prev_ss) begin
                checkOutput("ss_at_most_one_low", 32'($countones(~ss_n) <= 1), 32'd1);
            end
            if (!mon_active && ss_n != 4'hF) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_select", 32'd1, 32'd0);
                end else begin
                    cur        = exp_q.pop_front();
                    mon_active = 1'b1;
                    low_cycles = 1;
                    mon_edges  = 0;
                    mosi_cap   = '0;
                    drv_idx    = 0;
                    prev_sclk  = sclk;
                    exp_ss     = ~(4'b0001 << cur.ss);
                    checkOutput("ss_select", 32'(ss_n), 32'(exp_ss));
                    checkOutput("sclk_at_select", 32'(sclk), 32'(cur.cpol));
                    checkOutput("busy_at_select", 32'(busy), 32'd1);
                    checkOutput("ready_at_select", 32'(tx_ready), 32'd0);
                    if (!cur.cpha) begin
                        checkOutput("mosi_msb_setup", 32'(mosi), 32'(cur.data[W-1]));
                        miso    = cur.resp[W-1];
                        drv_idx = 1;
                    end
                end
            end else if (mon_active && ss_n != 4'hF) begin
                low_cycles++;
                exp_ss = ~(4'b0001 << cur.ss);
                if (ss_n !== prev_ss) checkOutput("ss_changed_mid_xfer", 32'(ss_n), 32'(exp_ss));
                if (sclk !== prev_sclk) begin
                    mon_edges++;
                    lead = (sclk != cur.cpol);
                    if (lead != cur.cpha) begin
                        mosi_cap = {mosi_cap[W-2:0], mosi};
                    end else if (drv_idx < W) begin
                        miso = cur.resp[W-1-drv_idx];
                        drv_idx++;
                    end
                    prev_sclk = sclk;
                end
            end else if (mon_active) begin
                mon_active = 1'b0;
                exp_rx     = cur.lb ? cur.data : cur.resp;
                checkOutput("ss_low_cycles", 32'(low_cycles), 32'((2 * W + 2) * (int'(cur.div) + 1)));
                checkOutput("sclk_edges", 32'(mon_edges), 32'(2 * W));
                checkOutput("mosi_word", 32'(mosi_cap), 32'(cur.data));
                checkOutput("rx_valid_done", 32'(rx_valid), 32'd1);
                checkOutput("rx_data", 32'(rx_data), 32'(exp_rx));
                checkOutput("busy_done", 32'(busy), 32'd0);
                checkOutput("sclk_done", 32'(sclk), 32'(cur.cpol));
            end
            prev_ss = ss_n;
        end
    end

    // Present one command and wait for it to be accepted; in_done reports
    // whether acceptance happened in the completion cycle of a prior word.
    task automatic applyStimulus(input logic [W-1:0] data, input logic [1:0] ss,
                                 input logic pol, input logic pha, input logic [7:0] div,
                                 input logic [W-1:0] resp, input logic lb,
                                 input bit keep_valid, output bit in_done);
        txn_t t;
        int   n = 0;
        @(negedge clk);
        tx_data  = data;
        tx_ss    = ss;
        cpol     = pol;
        cpha     = pha;
        clk_div  = div;
        tx_valid = 1'b1;
        while (!tx_ready && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        in_done = 1'b0;
        if (!tx_ready) begin
            checkOutput("accept_timeout", 32'd1, 32'd0);
            tx_valid = 1'b0;
            return;
        end
        in_done = rx_valid;
        t.data = data; t.ss = ss; t.cpol = pol; t.cpha = pha;
        t.div = div; t.resp = resp; t.lb = lb;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        if (!keep_valid) begin
            tx_valid = 1'b0;
            tx_data  = W'($urandom);
            tx_ss    = 2'($urandom);
            cpol     = 1'($urandom);
            cpha     = 1'($urandom);
            clk_div  = 8'($urandom);
        end
    endtask

    task automatic waitDone();
        int n = 0;
        while ((exp_q.size() != 0 || mon_active || !tx_ready) && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_timeout", 32'(n >= MAX_WAIT), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic runTxn(input logic [W-1:0] data, input logic [1:0] ss, input logic pol,
                          input logic pha, input logic [7:0] div, input logic [W-1:0] resp,
                          input logic lb);
        bit flag;
        applyStimulus(data, ss, pol, pha, div, resp, lb, 1'b0, flag);
        waitDone();
        exp_pulses++;
        checkOutput("idle_sclk_is_cpol", 32'(sclk), 32'(pol));
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        bit flag;
        int n;
        int pulses_before;

        // reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_sclk", 32'(sclk), 32'd0);
        checkOutput("rst_mosi", 32'(mosi), 32'd0);
        checkOutput("rst_ss_n", 32'(ss_n), 32'hF);
        checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(tx_ready), 32'd1);

        // the four modes with the same words
        for (int m = 0; m < 4; m++) begin
            runTxn(8'hA5, 2'd0, 1'(m >> 1), 1'(m & 1), 8'd1, 8'hCD, 1'b0);
        end

        // back-to-back with tx_valid held high
        applyStimulus(8'h3C, 2'd1, 1'b0, 1'b0, 8'd1, 8'h96, 1'b0, 1'b1, flag);
        applyStimulus(8'hC3, 2'd2, 1'b0, 1'b0, 8'd1, 8'h69, 1'b0, 1'b0, flag);
        checkOutput("b2b_accept_in_done", 32'(flag), 32'd1);
        waitDone();
        exp_pulses += 2;

        // divider extremes
        runTxn(8'h81, 2'd3, 1'b0, 1'b0, 8'd0, 8'h7E, 1'b0);
        runTxn(8'h1F, 2'd1, 1'b1, 1'b1, 8'd255, 8'hE2, 1'b0);

        // reset in the middle of a transfer
        pulses_before = rx_pulses;
        applyStimulus(8'h77, 2'd3, 1'b1, 1'b0, 8'd3, 8'h11, 1'b0, 1'b0, flag);
        n = 0;
        while (!(mon_active && mon_edges >= 5) && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("edge5_timeout", 32'(n >= MAX_WAIT), 32'd0);
        #2 rst = 1'b0;
        #1;
        checkOutput("abort_ss_n", 32'(ss_n), 32'hF);
        checkOutput("abort_sclk", 32'(sclk), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_rx_valid", 32'(rx_valid), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("abort_no_rx_pulse", 32'(rx_pulses), 32'(pulses_before));
        runTxn(8'h4B, 2'd2, 1'b0, 1'b1, 8'd2, 8'hB4, 1'b0);

        // randomized commands
        for (int i = 0; i < 10; i++) begin
            runTxn(W'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                   8'($urandom_range(0, 3)), W'($urandom), 1'b0);
        end

`ifdef SPI_LOOPBACK_EN
        // loopback: slave answers all zeros, received word must equal sent
        loopback = 1'b1;
        runTxn(8'h5A, 2'd0, 1'b0, 1'b0, 8'd1, 8'h00, 1'b1);
        runTxn(8'hC6, 2'd1, 1'b1, 1'b1, 8'd0, 8'h00, 1'b1);
        loopback = 1'b0;
`endif

        checkOutput("rx_pulse_count", 32'(rx_pulses), 32'(exp_pulses));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
